// File: rtl/fpu_ctrl_if.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : fpu_ctrl_if
// Description : Bundle of decode, FPU issue/result and writeback signals
//               between the FP sequencing controller and its environment.
// Revision    : 1.0 - initial release
// ============================================================================
interface fpu_ctrl_if;
  // decode side
  logic        inst_valid;
  logic        is_fp;
  logic [3:0]  alu_op;
  logic [4:0]  rd;
  logic [31:0] src1;
  logic [31:0] src2;
  logic        stall;
  // FPU issue side
  logic        distinct;
  logic        AorF;
  logic [3:0]  ALUOp;
  logic [31:0] op1;
  logic [31:0] op2;
  // FPU result side
  logic [31:0] fpu_result;
  logic        fpu_valid;
  logic        AorF_;
  // register-file writeback
  logic        wb_en_f;
  logic        wb_en_i;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  // status
  logic [15:0] busy_cycles;
  logic        timeout;

  // controller view
  modport master (
    input  inst_valid, is_fp, alu_op, rd, src1, src2,
    input  fpu_result, fpu_valid, AorF_,
    output stall, distinct, AorF, ALUOp, op1, op2,
    output wb_en_f, wb_en_i, wb_rd, wb_data, busy_cycles, timeout
  );

  // environment view (decoder, FPU, register file)
  modport slave (
    output inst_valid, is_fp, alu_op, rd, src1, src2,
    output fpu_result, fpu_valid, AorF_,
    input  stall, distinct, AorF, ALUOp, op1, op2,
    input  wb_en_f, wb_en_i, wb_rd, wb_data, busy_cycles, timeout
  );
endinterface
`default_nettype wire

// File: rtl/fpu_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : fpu_ctrl
// Description : Sequences one FP instruction at a time through the FPU:
//               latch, issue, wait for result (with timeout), write back,
//               drain. Stalls decode while an FP op is pending.
// Revision    : 1.0 - initial release
// ============================================================================
module fpu_ctrl #(
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic        CLK,
  input  logic        reset,
  fpu_ctrl_if.master  bus
);

  localparam int              CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    WAIT  = 3'd2,
    WB    = 3'd3,
    DRAIN = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic               distinct_q, distinct_d;
  logic               aorf_q, aorf_d;
  logic [3:0]         alu_op_q, alu_op_d;
  logic [31:0]        op1_q, op1_d;
  logic [31:0]        op2_q, op2_d;
  logic [4:0]         rd_q, rd_d;
  logic               wb_en_f_q, wb_en_f_d;
  logic               wb_en_i_q, wb_en_i_d;
  logic [4:0]         wb_rd_q, wb_rd_d;
  logic [31:0]        wb_data_q, wb_data_d;
  logic               timeout_q, timeout_d;
  logic [15:0]        busy_q, busy_d;
  logic [CNT_W-1:0]   wait_cnt_q, wait_cnt_d;

  logic               fp_req;
  logic               stall_now;

  assign fp_req = bus.inst_valid && bus.is_fp;

  // Stall is combinational so a new FP request in IDLE/DRAIN freezes decode
  // in the same cycle it appears; WB deliberately releases it.
  assign stall_now = (state_q == ISSUE) || (state_q == WAIT) ||
                     (fp_req && ((state_q == IDLE) || (state_q == DRAIN)));

  // Next-state and next-output computation for the sequencer.
  always_comb begin
    state_d    = state_q;
    distinct_d = 1'b0;
    aorf_d     = aorf_q;
    alu_op_d   = alu_op_q;
    op1_d      = op1_q;
    op2_d      = op2_q;
    rd_d       = rd_q;
    wb_en_f_d  = 1'b0;
    wb_en_i_d  = 1'b0;
    wb_rd_d    = wb_rd_q;
    wb_data_d  = wb_data_q;
    timeout_d  = timeout_q;
    wait_cnt_d = wait_cnt_q;
    busy_d     = (stall_now && (busy_q != 16'hFFFF)) ? busy_q + 16'd1 : busy_q;

    case (state_q)
      IDLE: begin
        aorf_d = 1'b0;
        if (fp_req) begin
          state_d    = ISSUE;
          alu_op_d   = bus.alu_op;
          op1_d      = bus.src1;
          op2_d      = bus.src2;
          rd_d       = bus.rd;
          distinct_d = 1'b1;
          aorf_d     = 1'b1;
        end
      end
      ISSUE: begin
        state_d    = WAIT;
        aorf_d     = 1'b1;
        wait_cnt_d = '0;
      end
      WAIT: begin
        if (bus.fpu_valid) begin
          state_d   = WB;
          aorf_d    = 1'b0;
          wb_data_d = bus.fpu_result;
          wb_en_f_d = bus.AorF_;
          wb_en_i_d = !bus.AorF_;
          wb_rd_d   = rd_q;
        end else if (wait_cnt_q == CNT_LAST) begin
          // abort: no writeback, straight to DRAIN
          state_d   = DRAIN;
          aorf_d    = 1'b0;
          timeout_d = 1'b1;
        end else begin
          aorf_d     = 1'b1;
          wait_cnt_d = wait_cnt_q + CNT_W'(1);
        end
      end
      WB: begin
        state_d = DRAIN;
        aorf_d  = 1'b0;
      end
      DRAIN: begin
        // a held-over fpu_valid is ignored here
        state_d = IDLE;
        aorf_d  = 1'b0;
      end
      default: begin
        state_d = IDLE;
        aorf_d  = 1'b0;
      end
    endcase
  end

  // Single state register: FSM state plus every registered output.
  always_ff @(posedge CLK) begin
    if (reset) begin
      state_q    <= IDLE;
      distinct_q <= 1'b0;
      aorf_q     <= 1'b0;
      alu_op_q   <= '0;
      op1_q      <= '0;
      op2_q      <= '0;
      rd_q       <= '0;
      wb_en_f_q  <= 1'b0;
      wb_en_i_q  <= 1'b0;
      wb_rd_q    <= '0;
      wb_data_q  <= '0;
      timeout_q  <= 1'b0;
      busy_q     <= '0;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      distinct_q <= distinct_d;
      aorf_q     <= aorf_d;
      alu_op_q   <= alu_op_d;
      op1_q      <= op1_d;
      op2_q      <= op2_d;
      rd_q       <= rd_d;
      wb_en_f_q  <= wb_en_f_d;
      wb_en_i_q  <= wb_en_i_d;
      wb_rd_q    <= wb_rd_d;
      wb_data_q  <= wb_data_d;
      timeout_q  <= timeout_d;
      busy_q     <= busy_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  assign bus.stall       = stall_now;
  assign bus.distinct    = distinct_q;
  assign bus.AorF        = aorf_q;
  assign bus.ALUOp       = alu_op_q;
  assign bus.op1         = op1_q;
  assign bus.op2         = op2_q;
  assign bus.wb_en_f     = wb_en_f_q;
  assign bus.wb_en_i     = wb_en_i_q;
  assign bus.wb_rd       = wb_rd_q;
  assign bus.wb_data     = wb_data_q;
  assign bus.timeout     = timeout_q;
  assign bus.busy_cycles = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_fpu_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_fpu_ctrl
// Description : Scoreboard bench for fpu_ctrl: directed FP ops, writeback
//               and issue expectations queued by stimulus, checked by monitor.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fpu_ctrl;
  localparam int TO = 16;

  logic CLK = 1'b0;
  logic reset = 1'b1;

  fpu_ctrl_if bus ();

  fpu_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
    .CLK   (CLK),
    .reset (reset),
    .bus   (bus)
  );

  always #5 CLK = ~CLK;

  typedef struct { logic f; logic [4:0] rd; logic [31:0] data; } wb_t;
  typedef struct { logic [3:0] op; logic [31:0] a; logic [31:0] b; } op_t;

  wb_t wb_q[$];
  op_t op_q[$];
  op_t cur_op;
  int  tests = 0;
  int  fails = 0;
  int  cyc = 0;
  int  aorf_cnt = 0;
  int  dist_cyc[$];
  int  wb_cyc[$];
  int  low_cyc[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Monitor: pops expectations whenever the DUT issues or writes back.
  always @(negedge CLK) begin
    cyc++;
    if (!reset) begin
      if (!bus.stall) low_cyc.push_back(cyc);
      if (bus.AorF) aorf_cnt++;
      if (bus.distinct) begin
        dist_cyc.push_back(cyc);
        chk("distinct_aorf", {31'd0, bus.AorF}, 32'd1);
        if (op_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_issue: distinct=1 with no instruction queued");
        end else begin
          cur_op = op_q.pop_front();
          chk("issue_aluop", {28'd0, bus.ALUOp}, {28'd0, cur_op.op});
          chk("issue_op1", bus.op1, cur_op.a);
          chk("issue_op2", bus.op2, cur_op.b);
        end
      end else if (bus.AorF) begin
        chk("hold_aluop", {28'd0, bus.ALUOp}, {28'd0, cur_op.op});
        chk("hold_op1", bus.op1, cur_op.a);
        chk("hold_op2", bus.op2, cur_op.b);
      end
      if (bus.wb_en_f || bus.wb_en_i) begin
        wb_t e;
        wb_cyc.push_back(cyc);
        chk("wb_exclusive", {31'd0, bus.wb_en_f & bus.wb_en_i}, 32'd0);
        if (wb_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_wb: wb_en_f=%0b wb_en_i=%0b with none expected",
                   bus.wb_en_f, bus.wb_en_i);
        end else begin
          e = wb_q.pop_front();
          chk("wb_en_f", {31'd0, bus.wb_en_f}, {31'd0, e.f});
          chk("wb_en_i", {31'd0, bus.wb_en_i}, {31'd0, !e.f});
          chk("wb_rd", {27'd0, bus.wb_rd}, {27'd0, e.rd});
          chk("wb_data", bus.wb_data, e.data);
        end
      end
    end
  end

  task automatic wait_distinct(output bit ok);
    int n = 0;
    @(negedge CLK);
    while (!bus.distinct && n < 20) begin
      @(negedge CLK);
      n++;
    end
    ok = bus.distinct;
    if (!ok) begin
      tests++; fails++;
      $display("FAIL issue_wait: distinct=0 after 20 cycles, required 1");
    end
  endtask

  task automatic present(input logic [3:0] op, input logic [4:0] rd,
                         input logic [31:0] a, input logic [31:0] b);
    bus.inst_valid = 1'b1;
    bus.is_fp      = 1'b1;
    bus.alu_op     = op;
    bus.rd         = rd;
    bus.src1       = a;
    bus.src2       = b;
    op_q.push_back('{op, a, b});
  endtask

  // One FP op: present, let the FPU answer after d extra WAIT cycles,
  // hold fpu_valid for 'hold' cycles. Returns inside WB or later.
  task automatic run_op(input logic [3:0] op, input logic [4:0] rd,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] res, input logic f,
                        input int d, input int hold);
    bit ok;
    present(op, rd, a, b);
    wait_distinct(ok);
    if (!ok) begin
      bus.inst_valid = 1'b0;
      return;
    end
    tick();
    repeat (d) tick();
    bus.fpu_valid  = 1'b1;
    bus.fpu_result = res;
    bus.AorF_      = f;
    wb_q.push_back('{f, rd, res});
    for (int h = 0; h < hold; h++) begin
      tick();
      if (h == 0) bus.inst_valid = 1'b0;
    end
    bus.fpu_valid = 1'b0;
  endtask

  task automatic chk_reset_vals();
    chk("rst_stall",    {31'd0, bus.stall},    32'd0);
    chk("rst_distinct", {31'd0, bus.distinct}, 32'd0);
    chk("rst_aorf",     {31'd0, bus.AorF},     32'd0);
    chk("rst_wb_en_f",  {31'd0, bus.wb_en_f},  32'd0);
    chk("rst_wb_en_i",  {31'd0, bus.wb_en_i},  32'd0);
    chk("rst_timeout",  {31'd0, bus.timeout},  32'd0);
    chk("rst_aluop",    {28'd0, bus.ALUOp},    32'd0);
    chk("rst_op1",      bus.op1,               32'd0);
    chk("rst_op2",      bus.op2,               32'd0);
    chk("rst_wb_rd",    {27'd0, bus.wb_rd},    32'd0);
    chk("rst_wb_data",  bus.wb_data,           32'd0);
    chk("rst_busy",     {16'd0, bus.busy_cycles}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w0, d0, a0, n, sp, lows;
    logic [15:0] b0;
    bit ok;
    bus.inst_valid = 1'b0; bus.is_fp = 1'b0; bus.alu_op = '0; bus.rd = '0;
    bus.src1 = '0; bus.src2 = '0;
    bus.fpu_result = '0; bus.fpu_valid = 1'b0; bus.AorF_ = 1'b0;

    // reset values
    repeat (3) tick();
    reset = 1'b0;
    @(negedge CLK);
    chk_reset_vals();

    // fadd -> float writeback; 5 stall cycles (accept, ISSUE, 3x WAIT)
    tick();
    run_op(4'b0011, 5'd5, 32'h3F800000, 32'h40000000, 32'h40400000, 1'b1, 2, 1);
    repeat (3) tick();
    chk("busy_after_fadd", {16'd0, bus.busy_cycles}, 32'd5);

    // fceq -> integer writeback, fpu_valid held two cycles
    w0 = wb_cyc.size(); d0 = dist_cyc.size();
    run_op(4'b1100, 5'd7, 32'h3F800000, 32'h3F800000, 32'h00000001, 1'b0, 0, 2);
    repeat (4) tick();
    chk("fceq_wb_count", wb_cyc.size() - w0, 1);
    chk("fceq_issue_count", dist_cyc.size() - d0, 1);

    // back-to-back FP instructions
    run_op(4'b0100, 5'd3, 32'h40400000, 32'h3F800000, 32'h40000000, 1'b1, 1, 1);
    run_op(4'b0101, 5'd10, 32'h40000000, 32'h40400000, 32'h40C00000, 1'b1, 1, 1);
    repeat (3) tick();
    #1;
    sp = dist_cyc[dist_cyc.size()-1] - wb_cyc[wb_cyc.size()-2];
    chk("b2b_issue_gap", sp, 3);
    lows = 0;
    foreach (low_cyc[i])
      if (low_cyc[i] > dist_cyc[dist_cyc.size()-2] && low_cyc[i] < dist_cyc[dist_cyc.size()-1])
        lows++;
    chk("b2b_stall_low_cycles", lows, 1);

    // non-FP instructions neither stall nor start the sequencer
    d0 = dist_cyc.size(); b0 = bus.busy_cycles;
    bus.inst_valid = 1'b1; bus.is_fp = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      chk("nonfp_stall", {31'd0, bus.stall}, 32'd0);
      tick();
    end
    bus.inst_valid = 1'b0;
    @(negedge CLK);
    #1;
    chk("nonfp_issue_count", dist_cyc.size() - d0, 0);
    chk("nonfp_busy", {16'd0, bus.busy_cycles}, {16'd0, b0});

    // timeout: FPU never answers
    tick();
    a0 = aorf_cnt; w0 = wb_cyc.size();
    present(4'b0111, 5'd9, 32'h11111111, 32'h22222222);
    wait_distinct(ok);
    tick();
    bus.inst_valid = 1'b0;
    n = 0;
    @(negedge CLK);
    while (!bus.timeout && n < 100) begin
      @(negedge CLK);
      n++;
    end
    chk("timeout_set", {31'd0, bus.timeout}, 32'd1);
    repeat (2) tick();
    @(negedge CLK);
    #1;
    chk("timeout_aorf_cycles", aorf_cnt - a0, TO + 1);
    chk("timeout_no_wb", wb_cyc.size() - w0, 0);
    chk("timeout_stall_released", {31'd0, bus.stall}, 32'd0);
    tick();
    run_op(4'b0001, 5'd12, 32'h0, 32'h0, 32'h12345678, 1'b0, 3, 1);
    repeat (3) tick();
    chk("timeout_sticky", {31'd0, bus.timeout}, 32'd1);

    // reset mid-WAIT, then a late fpu_valid pulse
    w0 = wb_cyc.size();
    present(4'b0011, 5'd20, 32'hAAAA5555, 32'h5555AAAA);
    wait_distinct(ok);
    tick();
    bus.inst_valid = 1'b0;
    repeat (3) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    bus.fpu_valid = 1'b1; bus.fpu_result = 32'hDEADBEEF; bus.AorF_ = 1'b1;
    tick();
    bus.fpu_valid = 1'b0;
    repeat (3) tick();
    @(negedge CLK);
    chk_reset_vals();
    #1;
    chk("reset_no_wb", wb_cyc.size() - w0, 0);

    chk("issue_queue_empty", op_q.size(), 0);
    chk("wb_queue_empty", wb_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
`default_nettype wire
